// File: rtl/uart_pkg.sv
// Shared definitions for the Wishbone UART: register offsets,
// status bit positions and FSM state encodings.
package uart_pkg;

    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_RXDATA  = 2'd1;
    localparam logic [1:0] UART_STATUS  = 2'd2;
    localparam logic [1:0] UART_DIVISOR = 2'd3;

    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_VALID   = 2;
    localparam int ST_RX_OVERRUN = 3;
    localparam int ST_FRAME_ERR  = 4;
    localparam int ST_TX_BUSY    = 5;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/wishbone_if.sv
// Wishbone bus bundle; data_in is master write data,
// data_out is slave read data.
interface wishbone_if;

    logic [31:0] address;
    logic        cycle;
    logic        strobe;
    logic        write_enable;
    logic [3:0]  select;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ack;

    modport master (
        output address, cycle, strobe, write_enable,
        output select, data_in,
        input  data_out, ack
    );

    modport slave (
        input  address, cycle, strobe, write_enable,
        input  select, data_in,
        output data_out, ack
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through read data.
// A full FIFO still accepts a push when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = count == (AW + 1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wishbone_uart.sv
// Wishbone slave UART: 8N1 TX with FIFO, single-entry RX holding
// register, status register and programmable baud divisor.
module wishbone_uart
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 868,
    parameter int TX_FIFO_DEPTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    wishbone_if.slave wb,
    output logic      uart_tx,
    input  logic      uart_rx
);
    localparam int CW = $clog2(TX_FIFO_DEPTH) + 1;

    logic          req, rd, wr;
    logic [1:0]    reg_sel;
    logic          tx_push, rd_rx, rd_status, wr_div;
    logic [15:0]   divisor, div_wr;
    logic [31:0]   rdata;
    logic [5:0]    status;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;
    logic          rx_valid, rx_overrun, frame_err;
    logic [7:0]    rx_byte;
    logic          unused_bits;

    tx_state_t     tx_state, tx_state_n;
    logic [15:0]   tx_cnt, tx_cnt_n, tx_div, tx_div_n;
    logic [2:0]    tx_idx, tx_idx_n;
    logic [7:0]    tx_shift, tx_shift_n;
    logic          tx_line_n, tx_tick, tx_frame;

    rx_state_t     rx_state, rx_state_n;
    logic [15:0]   rx_cnt, rx_cnt_n, rx_div, rx_div_n;
    logic [2:0]    rx_idx, rx_idx_n;
    logic [7:0]    rx_shift, rx_shift_n;
    logic          rx_s1, rx_s2, rx_s3;
    logic          rx_load, rx_ferr, rx_half_tick, rx_full_tick;

    assign req       = wb.cycle & wb.strobe & !wb.ack;
    assign reg_sel   = wb.address[3:2];
    assign wr        = req & wb.write_enable;
    assign rd        = req & !wb.write_enable;
    assign tx_push   = wr && reg_sel == UART_TXDATA && wb.select[0];
    assign rd_rx     = rd && reg_sel == UART_RXDATA;
    assign rd_status = rd && reg_sel == UART_STATUS;
    assign wr_div    = wr && reg_sel == UART_DIVISOR;

    assign unused_bits = ^{wb.address[31:4], wb.address[1:0],
                           wb.data_in[31:16], wb.select[3:2]};

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (fifo_pop),
        .din   (wb.data_in[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        div_wr = divisor;
        if (wb.select[0]) div_wr[7:0]  = wb.data_in[7:0];
        if (wb.select[1]) div_wr[15:8] = wb.data_in[15:8];
        if (div_wr < 16'd2) div_wr = 16'd2;
    end

    always_comb begin
        status                = '0;
        status[ST_TX_FULL]    = fifo_full;
        status[ST_TX_EMPTY]   = fifo_empty;
        status[ST_RX_VALID]   = rx_valid;
        status[ST_RX_OVERRUN] = rx_overrun;
        status[ST_FRAME_ERR]  = frame_err;
        status[ST_TX_BUSY]    = tx_state != TX_IDLE;
    end

    always_comb begin
        rdata = '0;
        unique case (reg_sel)
            UART_TXDATA:  rdata = '0;
            UART_RXDATA:  rdata = {24'd0, rx_byte};
            UART_STATUS:  rdata = {26'd0, status};
            UART_DIVISOR: rdata = {16'd0, divisor};
        endcase
    end

    // Set beats clear so an error landing on a STATUS read is kept.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb.ack      <= 1'b0;
            wb.data_out <= '0;
            divisor     <= 16'(CLKS_PER_BIT);
            rx_valid    <= 1'b0;
            rx_overrun  <= 1'b0;
            frame_err   <= 1'b0;
            rx_byte     <= '0;
        end else begin
            wb.ack      <= req;
            wb.data_out <= rd ? rdata : '0;
            if (wr_div) divisor <= div_wr;
            if (rd_status) begin
                rx_overrun <= 1'b0;
                frame_err  <= 1'b0;
            end
            if (rx_ferr) frame_err <= 1'b1;
            if (rx_load) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
                if (rx_valid && !rd_rx) rx_overrun <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign tx_tick = tx_cnt == tx_div - 16'd1;

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt + 16'd1;
        tx_div_n   = tx_div;
        tx_idx_n   = tx_idx;
        tx_shift_n = tx_shift;
        tx_line_n  = uart_tx;
        tx_frame   = 1'b0;
        fifo_pop   = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_n  = '0;
                tx_line_n = 1'b1;
                tx_frame  = 1'b1;
            end
            TX_START: if (tx_tick) begin
                tx_cnt_n   = '0;
                tx_idx_n   = '0;
                tx_line_n  = tx_shift[0];
                tx_state_n = TX_DATA;
            end
            TX_DATA: if (tx_tick) begin
                tx_cnt_n   = '0;
                tx_shift_n = {1'b0, tx_shift[7:1]};
                tx_line_n  = tx_shift[1];
                tx_idx_n   = tx_idx + 3'd1;
                if (tx_idx == 3'd7) begin
                    tx_line_n  = 1'b1;
                    tx_state_n = TX_STOP;
                end
            end
            TX_STOP: if (tx_tick) begin
                tx_cnt_n   = '0;
                tx_frame   = 1'b1;
                tx_state_n = TX_IDLE;
            end
            default: tx_state_n = TX_IDLE;
        endcase
        // Next frame starts straight from IDLE or STOP; divisor latched here.
        if (tx_frame && fifo_count != '0) begin
            fifo_pop   = 1'b1;
            tx_shift_n = fifo_dout;
            tx_div_n   = divisor;
            tx_cnt_n   = '0;
            tx_line_n  = 1'b0;
            tx_state_n = TX_START;
        end
    end

    assign rx_half_tick = rx_cnt == (rx_div >> 1) - 16'd1;
    assign rx_full_tick = rx_cnt == rx_div - 16'd1;

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 16'd1;
        rx_div_n   = rx_div;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_load    = 1'b0;
        rx_ferr    = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_s3 && !rx_s2) begin
                    rx_div_n   = divisor;
                    rx_state_n = RX_START;
                end
            end
            RX_START: if (rx_half_tick) begin
                rx_cnt_n   = '0;
                rx_idx_n   = '0;
                rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (rx_full_tick) begin
                rx_cnt_n   = '0;
                rx_shift_n = {rx_s2, rx_shift[7:1]};
                rx_idx_n   = rx_idx + 3'd1;
                if (rx_idx == 3'd7) rx_state_n = RX_STOP;
            end
            RX_STOP: if (rx_full_tick) begin
                rx_cnt_n   = '0;
                rx_load    = rx_s2;
                rx_ferr    = !rx_s2;
                rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_div   <= 16'(CLKS_PER_BIT);
            tx_idx   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_div   <= 16'(CLKS_PER_BIT);
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_s3    <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_div   <= tx_div_n;
            tx_idx   <= tx_idx_n;
            tx_shift <= tx_shift_n;
            uart_tx  <= tx_line_n;
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_div   <= rx_div_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
            rx_s1    <= uart_rx;
            rx_s2    <= rx_s1;
            rx_s3    <= rx_s2;
        end
    end

endmodule

// File: tb/tb_wishbone_uart.sv
// Directed bench for wishbone_uart: register access, TX framing,
// FIFO fill, RX receive/overrun/framing error and reset behaviour.
module tb_wishbone_uart;

    localparam logic [31:0] A_TX = 32'h1000_0000;
    localparam logic [31:0] A_RX = 32'h1000_0004;
    localparam logic [31:0] A_ST = 32'h1000_0008;
    localparam logic [31:0] A_DV = 32'h1000_000C;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_tx;
    logic uart_rx = 1'b1;
    int   checks = 0;
    int   failures = 0;

    wishbone_if bus ();

    wishbone_uart #(
        .CLKS_PER_BIT  (868),
        .TX_FIFO_DEPTH (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wb      (bus),
        .uart_tx (uart_tx),
        .uart_rx (uart_rx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wb_xfer(input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] sel,
                           output logic [31:0] rd, output int lat);
        bus.address      = a;
        bus.write_enable = we;
        bus.data_in      = wd;
        bus.select       = sel;
        bus.cycle        = 1'b1;
        bus.strobe       = 1'b1;
        lat = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            lat++;
            if (bus.ack === 1'b1) break;
        end
        rd = bus.data_out;
        bus.cycle        = 1'b0;
        bus.strobe       = 1'b0;
        bus.write_enable = 1'b0;
        check("wb_ack", {31'd0, bus.ack}, 32'd1);
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] sel);
        logic [31:0] unused_rd;
        int          unused_lat;
        wb_xfer(1'b1, a, d, sel, unused_rd, unused_lat);
    endtask

    task automatic expect_read(input string tag, input logic [31:0] a,
                               input logic [31:0] mask,
                               input logic [31:0] exp);
        logic [31:0] d;
        int          lat;
        wb_xfer(1'b0, a, 32'd0, 4'hF, d, lat);
        check(tag, d & mask, exp);
    endtask

    task automatic capture_frame(output logic [7:0] b, output int waited);
        waited = 0;
        for (int k = 0; k < 200; k++) begin
            if (uart_tx === 1'b0) break;
            tick(1);
            waited++;
        end
        check("cap_start_found", {31'd0, uart_tx}, 32'd0);
        tick(2);
        check("cap_start_bit", {31'd0, uart_tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick(4);
            b[i] = uart_tx;
        end
        tick(4);
        check("cap_stop_bit", {31'd0, uart_tx}, 32'd1);
    endtask

    task automatic send_serial(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        tick(4);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(4);
        end
        uart_rx = stop;
        tick(4);
        uart_rx = 1'b1;
        tick(8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  exp_bits;
        int          lat;
        int          n;

        bus.address      = '0;
        bus.cycle        = 1'b0;
        bus.strobe       = 1'b0;
        bus.write_enable = 1'b0;
        bus.select       = '0;
        bus.data_in      = '0;

        tick(3);
        check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
        check("rst_ack", {31'd0, bus.ack}, 32'd0);
        check("rst_data_out", bus.data_out, 32'd0);
        reset = 1'b0;
        tick(1);

        wb_xfer(1'b0, A_ST, 32'd0, 4'hF, d, lat);
        check("status_reset", d, 32'h0000_0002);
        check("ack_latency", lat, 32'd1);
        tick(1);
        check("ack_drop", {31'd0, bus.ack}, 32'd0);
        check("data_out_idle", bus.data_out, 32'd0);

        expect_read("div_reset", 32'h1ABC_000C, '1, 32'h0000_0364);
        expect_read("txdata_read", A_TX, '1, 32'd0);

        wb_write(A_DV, 32'h0000_00AB, 4'b0001);
        expect_read("div_lane0", A_DV, '1, 32'h0000_03AB);
        wb_write(A_DV, 32'h0000_0001, 4'b0011);
        expect_read("div_min", A_DV, '1, 32'h0000_0002);
        wb_write(A_DV, 32'h0000_0004, 4'b0011);
        expect_read("div_four", A_DV, '1, 32'h0000_0004);

        wb_write(A_TX, 32'h0000_0077, 4'b0010);
        expect_read("no_push_lane", A_ST, '1, 32'h0000_0002);

        exp_bits = 8'h55;
        wb_write(A_TX, 32'h0000_0055, 4'b0001);
        n = 0;
        for (int k = 0; k < 4; k++) begin
            if (uart_tx === 1'b0) break;
            tick(1);
            n++;
        end
        check("tx_start_latency", {31'd0, n >= 1 && n <= 2}, 32'd1);
        tick(2);
        check("tx_start_bit", {31'd0, uart_tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                expect_read("tx_busy", A_ST, '1, 32'h0000_0022);
                tick(3);
            end else begin
                tick(4);
            end
            check($sformatf("tx_bit%0d", i), {31'd0, uart_tx},
                  {31'd0, exp_bits[i]});
        end
        tick(4);
        check("tx_stop_bit", {31'd0, uart_tx}, 32'd1);
        tick(4);
        expect_read("tx_done", A_ST, '1, 32'h0000_0002);

        fork
            begin
                for (int i = 0; i < 9; i++)
                    wb_write(A_TX, i, 4'b0001);
                expect_read("fifo_full", A_ST, '1, 32'h0000_0021);
                wb_write(A_TX, 32'h0000_0099, 4'b0001);
            end
            begin
                logic [7:0] b;
                int         w;
                for (int f = 0; f < 9; f++) begin
                    capture_frame(b, w);
                    check($sformatf("frame%0d_byte", f), {24'd0, b}, f);
                    if (f > 0)
                        check($sformatf("frame%0d_gap", f), w, 32'd2);
                end
            end
        join
        tick(8);
        expect_read("fifo_drop", A_ST, '1, 32'h0000_0002);

        uart_rx = 1'b0;
        tick(1);
        uart_rx = 1'b1;
        tick(12);
        expect_read("rx_glitch", A_ST, '1, 32'h0000_0002);

        send_serial(8'hA3, 1'b1);
        expect_read("rx_valid", A_ST, '1, 32'h0000_0006);
        expect_read("rx_byte_a3", A_RX, '1, 32'h0000_00A3);
        expect_read("rx_cleared", A_ST, '1, 32'h0000_0002);

        send_serial(8'h3C, 1'b1);
        send_serial(8'hC5, 1'b1);
        expect_read("rx_overrun", A_ST, 32'h1C, 32'h0000_000C);
        expect_read("rx_byte_c5", A_RX, '1, 32'h0000_00C5);
        expect_read("overrun_clr", A_ST, '1, 32'h0000_0002);

        send_serial(8'h11, 1'b1);
        send_serial(8'h5A, 1'b0);
        expect_read("frame_err", A_ST, '1, 32'h0000_0016);
        expect_read("frame_err_clr", A_ST, '1, 32'h0000_0006);
        expect_read("rx_byte_kept", A_RX, '1, 32'h0000_0011);

        wb_write(A_TX, 32'h0000_000F, 4'b0001);
        for (int k = 0; k < 4; k++) begin
            if (uart_tx === 1'b0) break;
            tick(1);
        end
        tick(2);
        check("pre_reset_low", {31'd0, uart_tx}, 32'd0);
        reset = 1'b1;
        tick(1);
        check("reset_tx_high", {31'd0, uart_tx}, 32'd1);
        reset = 1'b0;
        tick(1);
        expect_read("reset_status", A_ST, '1, 32'h0000_0002);
        expect_read("reset_div", A_DV, '1, 32'h0000_0364);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wishbone_uart.md
Name: wishbone_uart

Overview:
- Wishbone slave UART peripheral on the switch's UART port, decoded at 0x1000_0000–0x1FFF_FFFF; the switch passes the address through unmodified.
- Provides 8N1 serial TX and RX, a TX FIFO, a single-entry RX holding register, a status register and a runtime-programmable baud divisor.
- Serves LSU loads and stores only.

Parameters:
- CLKS_PER_BIT, 868, reset value of the baud divisor (100 MHz / 115200).
- TX_FIFO_DEPTH, 8, TX FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- wb  slave  wishbone_if.slave  bus port. Fields:
  - address 32
  - cycle 1
  - strobe 1
  - write_enable 1
  - select 4
  - data_in 32
  - data_out 32 (driven)
  - ack 1 (driven)
- uart_tx  output  1  serial out, idle high.
- uart_rx  input  1  serial in, asynchronous.

Behaviour:
- Reset: ack=0, data_out=0, uart_tx=1, FIFO empty, rx_valid=0, rx_overrun=0, frame_err=0, divisor=CLKS_PER_BIT, both FSMs in IDLE.
- Register map (decode address[3:2] only; upper bits ignored):
  - 0x0 TXDATA. Write: data_in[7:0] pushed when select[0]=1. Read returns 0.
  - 0x4 RXDATA. Read: {24'b0, rx_byte}, clears rx_valid. Write ignored.
  - 0x8 STATUS (read-only). Bit0 tx_full, bit1 tx_empty, bit2 rx_valid, bit3 rx_overrun, bit4 frame_err, bit5 tx_busy (FSM not IDLE). Reading clears bits 3 and 4.
  - 0xC DIVISOR. R/W, bits [15:0], byte lanes honoured via select[1:0]. Values below 2 are written as 2.
- Handshake:
  - Request = cycle & strobe & !ack.
  - ack is registered: asserted exactly one cycle after the request cycle, held one cycle, then cleared. Back-to-back requests are therefore acked every second cycle.
  - data_out is valid in the ack cycle and 0 otherwise.
  - Side effects (push, pop, clear) happen once, in the request cycle.
- TX FIFO:
  - A push when full is dropped silently and still acked.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- TX FSM, states IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE: when FIFO not empty, pop and latch the byte, move to START.
  - Each bit lasts divisor clocks. START drives 0, DATA drives 8 bits LSB first, STOP drives 1.
  - From STOP, go to START directly if the FIFO is non-empty, so there is no idle gap.
  - The divisor is sampled at the start of each frame; a mid-frame write takes effect on the next frame.
- RX path:
  - uart_rx passes through a 2-flop synchroniser.
  - FSM states IDLE -> START -> DATA -> STOP.
  - IDLE: a falling edge starts a half-bit count.
  - START: at mid-bit, if the line is high it is a glitch, return to IDLE; otherwise count a full bit per sample.
  - DATA: 8 samples at bit centres, LSB first.
  - STOP: sample at centre. If 0, set frame_err and discard the byte. If 1, load rx_byte and set rx_valid; if rx_valid was already 1, set rx_overrun and overwrite the byte.
  - A same-cycle RXDATA read and new-byte load leave rx_valid=1 with the new byte, and do not flag overrun.
- Reset mid-frame: uart_tx returns high within the same cycle edge and any partial frame is discarded.

Decomposition:
- Package uart_pkg holds:
  - register offset constants (UART_TXDATA, UART_RXDATA, UART_STATUS, UART_DIVISOR)
  - status bit index constants
  - the tx_state_t and rx_state_t enums
- Sub-module sync_fifo (parameter WIDTH=8, DEPTH) with push/pop/full/empty/count.
- TX and RX FSMs stay in wishbone_uart.

Test Plan:
- Reset, then read STATUS -> data_out=0x0000_0002 (tx_empty only), ack exactly 1 cycle after the request; DIVISOR reads 0x364.
- Write DIVISOR=4, write TXDATA=0x55 -> uart_tx goes low 1–2 cycles after ack, then bits 1,0,1,0,1,0,1,0 at 4 clocks each, then stop high; tx_busy=1 during the frame.
- With DIVISOR=4, write 9 bytes 0x00..0x08 back-to-back -> first byte goes to the TX shift register, next 8 fill the FIFO, tx_full=1 is seen, 0x08 is dropped or kept according to fill timing as computed by the model; consecutive frames show no idle gap.
- Drive serial 0xA3 on uart_rx (DIVISOR=4) -> STATUS bit2=1; RXDATA read returns 0x0000_00A3; a second STATUS read shows bit2=0.
- Send two RX bytes without reading -> STATUS=0x0C with rx_overrun; RXDATA=second byte; the next STATUS read shows bit3 cleared.
- Send an RX frame with stop bit 0 -> frame_err=1 and rx_valid unchanged. Assert reset mid-TX-frame -> uart_tx=1 the next cycle and STATUS=0x02.
